// File: rtl/ascon_permutation_if.sv
// Request/response bundle between the mode controller (master) and the
// iterative Ascon permutation engine (slave).
interface ascon_permutation_if;
  // Handshake: the master raises permutation_start with rounds/state_in valid and
  // holds it high until it samples permutation_ready; the slave then holds
  // permutation_ready and state_out stable until permutation_start drops.
  // Dropping permutation_start before permutation_ready aborts the request.
  logic         permutation_start;
  logic [3:0]   rounds;
  logic [319:0] state_in;
  logic         permutation_ready;
  logic [319:0] state_out;
  logic         busy;

  modport master (
    output permutation_start,
    output rounds,
    output state_in,
    input  permutation_ready,
    input  state_out,
    input  busy
  );

  modport slave (
    input  permutation_start,
    input  rounds,
    input  state_in,
    output permutation_ready,
    output state_out,
    output busy
  );
endinterface

// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation: one round per clock (two per clock when
// ASCON_PERM_DOUBLE_ROUND_EN is defined), selectable 1..12 rounds per request.
module ascon_permutation #(
  parameter int MAX_ROUNDS = 12
) (
  input  logic               clk,
  input  logic               rst,
  ascon_permutation_if.slave perm,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t         state_q;
  fsm_t         state_d;
  logic [319:0] s_q;
  logic [319:0] s_next;
  logic [3:0]   remaining_q;
  logic [3:0]   rc_idx_q;
  logic [3:0]   rem_next;
  logic [3:0]   rc_next;
  logic [3:0]   eff_rounds;
  logic         last_step;
  logic         load;
  logic         advance;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One full Ascon round: constant addition, bitsliced S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] rc);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];

    x2 = x2 ^ {56'd0, 4'hF - rc, rc};

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Out-of-range round requests (0, 13..15) fall back to the full permutation.
  always_comb begin
    eff_rounds = perm.rounds;
    if (perm.rounds == 4'd0 || perm.rounds > 4'(MAX_ROUNDS)) begin
      eff_rounds = 4'(MAX_ROUNDS);
    end
  end

`ifdef ASCON_PERM_DOUBLE_ROUND_EN
  logic [319:0] round_a;
  logic [319:0] round_b;

  // With an odd count the final cycle keeps only the first cascaded round.
  always_comb begin
    round_a   = ascon_round(s_q, rc_idx_q);
    round_b   = ascon_round(round_a, rc_idx_q + 4'd1);
    last_step = (remaining_q <= 4'd2);
    s_next    = (remaining_q == 4'd1) ? round_a : round_b;
    rem_next  = (remaining_q >= 4'd2) ? remaining_q - 4'd2 : 4'd0;
    rc_next   = rc_idx_q + 4'd2;
  end
`else
  always_comb begin
    last_step = (remaining_q <= 4'd1);
    s_next    = ascon_round(s_q, rc_idx_q);
    rem_next  = (remaining_q != 4'd0) ? remaining_q - 4'd1 : 4'd0;
    rc_next   = rc_idx_q + 4'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (perm.permutation_start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!perm.permutation_start) begin
          state_d = IDLE;
        end else begin
          advance = 1'b1;
          if (last_step) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!perm.permutation_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q         <= '0;
      remaining_q <= '0;
      rc_idx_q    <= '0;
    end else if (load) begin
      s_q         <= perm.state_in;
      remaining_q <= eff_rounds;
      rc_idx_q    <= 4'(MAX_ROUNDS) - eff_rounds;
    end else if (advance) begin
      s_q         <= s_next;
      remaining_q <= rem_next;
      rc_idx_q    <= rc_next;
    end
  end

  assign perm.permutation_ready = (state_q == DONE);
  assign perm.busy              = (state_q == RUN);
  assign perm.state_out         = s_q;
  assign fsm_state              = state_q;

endmodule

// File: tb/tb_ascon_permutation.sv
// Randomized scoreboard bench for ascon_permutation against a table-driven
// software model of the Ascon permutation.
module tb_ascon_permutation;
  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  ascon_permutation_if pif ();

  ascon_permutation #(.MAX_ROUNDS(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .perm      (pif.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  logic [4:0] sbox_tab [32];
  initial sbox_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic int eff_of(input int r);
    return (r == 0 || r > 12) ? 12 : r;
  endfunction

  function automatic int latency_of(input int r);
`ifdef ASCON_PERM_DOUBLE_ROUND_EN
    return 1 + (eff_of(r) + 1) / 2;
`else
    return 1 + eff_of(r);
`endif
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s_in, input int r);
    logic [63:0]  x [5];
    logic [4:0]   col;
    logic [4:0]   o;
    logic [7:0]   c;
    logic [319:0] res;
    int           n;
    int           ci;
    n = eff_of(r);
    for (int w = 0; w < 5; w++) x[w] = s_in[319 - 64 * w -: 64];
    for (int k = 0; k < n; k++) begin
      ci = 12 - n + k;
      c = 8'(((15 - ci) << 4) | ci);
      x[2] = x[2] ^ {56'd0, c};
      for (int j = 0; j < 64; j++) begin
        col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o = sbox_tab[col];
        x[0][j] = o[4]; x[1][j] = o[3]; x[2][j] = o[2]; x[3][j] = o[1]; x[4][j] = o[0];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    for (int w = 0; w < 5; w++) res[319 - 64 * w -: 64] = x[w];
    return res;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check_wide(input string name, input logic [319:0] got, input logic [319:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [319:0] exp_q [$];
  int           lat_q [$];
  logic [319:0] cur_exp;
  bit           have_cur = 0;
  bit           prev_start = 0;
  bit           prev_ready = 0;
  int           req_cyc = 0;
  int           busy_cnt = 0;

  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (pif.permutation_start && !prev_start) begin
        req_cyc  = cyc;
        busy_cnt = 0;
      end
      if (pif.busy) busy_cnt++;
      if (pif.busy && pif.permutation_ready) begin
        check_int("busy_ready_overlap", 1, 0);
      end
      if (pif.permutation_ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          check_int("unexpected_ready", 1, 0);
          have_cur = 0;
        end else begin
          cur_exp = exp_q.pop_front();
          lat     = lat_q.pop_front();
          check_wide("state_out", pif.state_out, cur_exp);
          check_int("latency", cyc - req_cyc, lat);
          check_int("busy_cycles", busy_cnt, lat - 1);
          have_cur = 1;
        end
      end else if (pif.permutation_ready && have_cur) begin
        check_wide("state_out_hold", pif.state_out, cur_exp);
      end
      if (!pif.permutation_ready) have_cur = 0;
      prev_start = pif.permutation_start;
      prev_ready = pif.permutation_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32 * i +: 32] = $urandom;
    return s;
  endfunction

  task automatic start_req(input logic [319:0] s, input logic [3:0] r, input bit expect_result);
    pif.permutation_start = 1'b1;
    pif.rounds            = r;
    pif.state_in          = s;
    if (expect_result) begin
      exp_q.push_back(ref_perm(s, int'(r)));
      lat_q.push_back(latency_of(int'(r)));
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      // Inputs after acceptance must not influence the result.
      pif.state_in = rand_state();
      pif.rounds   = 4'($urandom_range(0, 15));
      if (pif.permutation_ready) begin
        ok = 1;
        return;
      end
    end
    check_int("ready_timeout", 0, 1);
  endtask

  task automatic hold_and_release(input int hold);
    for (int h = 0; h < hold; h++) begin
      step();
      check_int("ready_held", int'(pif.permutation_ready), 1);
    end
    pif.permutation_start = 1'b0;
    step();
    check_int("ready_release", int'(pif.permutation_ready), 0);
  endtask

  task automatic run_req(input logic [319:0] s, input logic [3:0] r, input int hold);
    bit ok;
    start_req(s, r, 1'b1);
    wait_ready(ok);
    if (ok) begin
      hold_and_release(hold);
    end else begin
      pif.permutation_start = 1'b0;
      step();
      step();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_ready"}, int'(pif.permutation_ready), 0);
    check_int({tag, "_busy"}, int'(pif.busy), 0);
    check_wide({tag, "_state_out"}, pif.state_out, 320'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [319:0] ascon_init;
  initial begin
    bit ok;
    ascon_init = {64'h80400c0600000000,
                  128'h000102030405060708090a0b0c0d0e0f,
                  128'h000102030405060708090a0b0c0d0e0f};
    rst = 1'b0;
    pif.permutation_start = 1'b0;
    pif.rounds = 4'd0;
    pif.state_in = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    run_req(320'd0, 4'd12, 0);
    run_req(ascon_init, 4'd12, 0);
    run_req(ascon_init, 4'd6, 0);
    run_req(ascon_init, 4'd8, 0);
    run_req(ascon_init, 4'd0, 0);
    run_req(ascon_init, 4'd15, 0);

    // Abort after 5 RUN cycles, then a fresh p6 request two cycles later.
    start_req(rand_state(), 4'd12, 1'b0);
    for (int i = 0; i < 6; i++) step();
    pif.permutation_start = 1'b0;
    step();
    step();
    run_req(rand_state(), 4'd6, 0);

    // Held start must not retrigger; back-to-back request after one low cycle.
    run_req(rand_state(), 4'd12, 4);
    run_req(rand_state(), 4'd3, 0);

    // Reset in the middle of RUN, start still asserted.
    start_req(rand_state(), 4'd12, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    step();
    check_reset_outputs("rst_run");
    pif.permutation_start = 1'b0;
    rst = 1'b1;
    step();
    run_req(rand_state(), 4'd7, 1);

    // Reset while in DONE, start still asserted.
    start_req(rand_state(), 4'd5, 1'b1);
    wait_ready(ok);
    step();
    rst = 1'b0;
    step();
    check_reset_outputs("rst_done");
    pif.permutation_start = 1'b0;
    rst = 1'b1;
    step();
    run_req(rand_state(), 4'd12, 0);

    for (int n = 0; n < 10; n++) begin
      run_req(rand_state(), 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    step();
    step();
    check_int("pending_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=stalled want=finished");
    $fatal(1);
  end

endmodule

// File: doc/ascon_permutation.md
# ascon_permutation

Iterative Ascon permutation engine: the responder side of the `permutation_start` / `permutation_ready` handshake driven by the mode controller. It latches a 320-bit state on request and applies one Ascon round per clock (constant addition, S-box layer, linear diffusion layer). The round count is selectable per request (p12, p8, p6 or any 1..12). It returns the permuted state with `permutation_ready` held until the initiator releases the request.

## Interface
- `MAX_ROUNDS`, default 12: round-constant table depth; round index base is `MAX_ROUNDS - rounds`. Only 12 is supported.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `permutation_start`  in  1  request; initiator holds high from request until it samples `permutation_ready`.
- `rounds`  in  4  requested round count; sampled only at request acceptance.
- `state_in`  in  320  input state; x0 = [319:256], x1 = [255:192], x2 = [191:128], x3 = [127:64], x4 = [63:0]; sampled only at acceptance.
- `permutation_ready`  out  1  result valid; level, held while in DONE.
- `state_out`  out  320  permuted state, same word layout; valid while `permutation_ready` = 1.
- `busy`  out  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with `permutation_start` = 1:
  - load `state_in` into the state register;
  - load `remaining` = effective rounds;
  - load `rc_idx` = 12 − effective rounds;
  - go to RUN.
- Effective rounds: `rounds` if 1..12; values 0 and 13..15 map to 12.
- RUN, each cycle:
  - apply one round with constant c = ((0xF − rc_idx) << 4) | rc_idx, XORed into the low byte of x2;
  - increment `rc_idx` and decrement `remaining`;
  - when `remaining` reaches 0, go to DONE.
- Round function:
  - S-box: 5-bit Ascon χ-based S-box, bitsliced across x0..x4.
  - Linear layer:
    - x0 ^= ror19 ^ ror28
    - x1 ^= ror61 ^ ror39
    - x2 ^= ror1 ^ ror6
    - x3 ^= ror10 ^ ror17
    - x4 ^= ror7 ^ ror41
- DONE:
  - `permutation_ready` = 1 and `state_out` = state register, both held stable;
  - go to IDLE on the first cycle `permutation_start` = 0.
  - `permutation_start` remaining high does not retrigger.
- Abort: `permutation_start` = 0 during RUN returns the FSM to IDLE next edge. `permutation_ready` is never asserted for that request; the state register contents are don't-care.
- `rounds` and `state_in` changes after acceptance are ignored.
- `state_out` is driven directly from the state register at all times; it is defined only while `permutation_ready` = 1.

## Timing
- Reset (`rst` = 0 at a rising edge):
  - FSM = IDLE, `remaining` = 0, `rc_idx` = 0, state register = 0;
  - `permutation_ready` = 0, `busy` = 0, `state_out` = 0.
- Reset wins over every other event, including mid-RUN and DONE.
- Acceptance edge E0 (IDLE, start = 1). RUN occupies edges E1..Er. `permutation_ready` is high from after Er until the edge where start is sampled low.
- Latency: `permutation_ready` first visible r+1 cycles after start is first sampled high. p12 gives 13, p6 gives 7.
- Minimum turnaround: start low for 1 cycle; next acceptance ≥ 1 cycle after DONE exits.
- `busy` and `permutation_ready` are never high together.

## Configuration
- `ASCON_PERM_DOUBLE_ROUND_EN` defined: two cascaded round instances evaluated per RUN cycle.
  - `rc_idx` advances by 2 and `remaining` decrements by 2.
  - For odd r, the final RUN cycle applies only the first round.
  - RUN lasts ceil(r/2) cycles, so latency = 1 + ceil(r/2): p12 gives 7, p6 gives 4.
- Undefined: single round per cycle as above. Ports and handshake are identical in both builds.

## Test plan
- All-zero state, rounds = 12, start held → `permutation_ready` rises exactly 13 cycles after start (7 with the macro). `state_out` equals the software-model p12(0); `busy` high for exactly 12 (6) cycles.
- Ascon-128 initialization: state = 0x80400c0600000000 ‖ key 0x000102…0f ‖ nonce 0x000102…0f, rounds = 12 → `state_out` matches the software model. Repeat with rounds = 6 and rounds = 8, starting from rc_idx 6 and 4 respectively.
- rounds = 0 and rounds = 15 → identical result and latency to rounds = 12.
- Start dropped after 5 RUN cycles, then re-raised 2 cycles later with a new state, rounds = 6 → first request never signals ready; second returns the correct p6 result at 7-cycle latency.
- Start held high for 4 cycles past ready → `permutation_ready` and `state_out` stable throughout, no retrigger. Start low for 1 cycle → IDLE; next start accepted on the following cycle.
- `rst` = 0 asserted mid-RUN and again in DONE → next edge: `permutation_ready` = 0, `busy` = 0, `state_out` = 0; a subsequent request completes normally.
